// File: rtl/sram_device_model_if.sv
// Control/address side of the external 16-bit asynchronous SRAM pin interface.
// The controller drives every signal here; the device model only observes them.
interface sram_device_model_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_WE_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_device_model.sv
// Clocked behavioural model of an external 16-bit asynchronous SRAM (responder side).
// Define SRAM_MODEL_CHECK_EN to add the sticky proto_err protocol checker output.
module sram_device_model #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 65536,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_device_model_if.slave   sram,
  inout  wire  [DATA_W-1:0]    SRAM_DQ,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count,
  output logic                 busy
`ifdef SRAM_MODEL_CHECK_EN
  ,
  output logic                 proto_err
`endif
);

  localparam int         IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    DRIVE,
    WRITE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [ADDR_W-1:0]   addr;
  logic                sel;
  logic                we_n;
  logic                oe_n;
  logic                ub_n;
  logic                lb_n;
  logic                wr_commit;
  logic                load_dout;
  logic                dq_oe;

  assign addr = sram.SRAM_ADDR;
  assign sel  = ~sram.SRAM_CE_N;
  assign we_n = sram.SRAM_WE_N;
  assign oe_n = sram.SRAM_OE_N;
  assign ub_n = sram.SRAM_UB_N;
  assign lb_n = sram.SRAM_LB_N;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Priority within each state follows the pin protocol: deselect, then write, then address change.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    rd_count_d = rd_count_q;
    wr_commit  = 1'b0;
    load_dout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !we_n) begin
          state_d   = WRITE;
          wr_commit = 1'b1;
        end else if (sel && !oe_n) begin
          state_d   = RD_WAIT;
          addr_d    = addr;
          lat_cnt_d = LAT_INIT;
        end
      end
      RD_WAIT: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (!we_n) begin
          state_d   = WRITE;
          wr_commit = 1'b1;
        end else if (addr != addr_q) begin
          addr_d    = addr;
          lat_cnt_d = LAT_INIT;
        end else if (lat_cnt_q == 3'd0) begin
          state_d    = DRIVE;
          load_dout  = 1'b1;
          rd_count_d = rd_count_q + CNT_W'(1);
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      DRIVE: begin
        if (!sel || oe_n) begin
          state_d = IDLE;
        end else if (!we_n) begin
          state_d   = WRITE;
          wr_commit = 1'b1;
        end else if (addr != addr_q) begin
          state_d   = RD_WAIT;
          addr_d    = addr;
          lat_cnt_d = LAT_INIT;
        end
      end
      WRITE: begin
        if (sel && !we_n) begin
          wr_commit = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_count_d = wr_commit ? wr_count_q + CNT_W'(1) : wr_count_q;
    dout_d     = load_dout ? mem[addr_q[IDX_W-1:0]] : dout_q;
  end

  // Memory is never cleared; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_commit) begin
      if (!ub_n) mem[addr[IDX_W-1:0]][15:8] <= SRAM_DQ[15:8];
      if (!lb_n) mem[addr[IDX_W-1:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    dq_oe = (state_q == DRIVE) && sel && !oe_n && we_n;
  end

  assign SRAM_DQ  = dq_oe ? dout_q : {DATA_W{1'bz}};
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

`ifdef SRAM_MODEL_CHECK_EN
  logic proto_err_q, proto_err_d;
  logic err_we_oe;
  logic err_mask;
  logic err_x;

  always_comb begin
    err_we_oe   = sel && !we_n && !oe_n;
    err_mask    = wr_commit && ub_n && lb_n;
    err_x       = 1'b0;
`ifndef SYNTHESIS
    err_x       = wr_commit && ((!ub_n && $isunknown(SRAM_DQ[15:8])) ||
                                (!lb_n && $isunknown(SRAM_DQ[7:0])));
`endif
    proto_err_d = proto_err_q || err_we_oe || err_mask || err_x;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) proto_err_q <= 1'b0;
    else      proto_err_q <= proto_err_d;
  end

  assign proto_err = proto_err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && (err_we_oe || err_mask || err_x))
      $display("[%0t] sram_device_model: protocol error we_oe=%0b mask=%0b x=%0b",
               $time, err_we_oe, err_mask, err_x);
  end
`endif
`endif

endmodule

// File: tb/tb_sram_device_model.sv
// Directed self-checking bench for sram_device_model: two instances, RD_LAT=1 and RD_LAT=3.
// Released buses are pulled up, so a high-Z bus reads back as 16'hFFFF.
module tb_sram_device_model;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_device_model_if #(.ADDR_W(18)) if_a ();
  sram_device_model_if #(.ADDR_W(18)) if_b ();

  wire  [15:0] dq_a;
  wire  [15:0] dq_b;
  logic        tb_drv_a = 1'b0;
  logic [15:0] tb_dq_a  = 16'h0000;
  logic        tb_drv_b = 1'b0;
  logic [15:0] tb_dq_b  = 16'h0000;

  assign dq_a = tb_drv_a ? tb_dq_a : 16'hzzzz;
  assign dq_b = tb_drv_b ? tb_dq_b : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (dq_a[i]);
    pullup (dq_b[i]);
  end

  logic [15:0] rd_count_a, wr_count_a, rd_count_b, wr_count_b;
  logic        busy_a, busy_b;
`ifdef SRAM_MODEL_CHECK_EN
  logic        proto_err_a, proto_err_b;
`endif

  sram_device_model #(
    .ADDR_W(18), .DATA_W(16), .MEM_DEPTH(65536), .RD_LAT(1), .CNT_W(16)
  ) dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .sram     (if_a.slave),
    .SRAM_DQ  (dq_a),
    .rd_count (rd_count_a),
    .wr_count (wr_count_a),
    .busy     (busy_a)
`ifdef SRAM_MODEL_CHECK_EN
    ,
    .proto_err(proto_err_a)
`endif
  );

  sram_device_model #(
    .ADDR_W(18), .DATA_W(16), .MEM_DEPTH(65536), .RD_LAT(3), .CNT_W(16)
  ) dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .sram     (if_b.slave),
    .SRAM_DQ  (dq_b),
    .rd_count (rd_count_b),
    .wr_count (wr_count_b),
    .busy     (busy_b)
`ifdef SRAM_MODEL_CHECK_EN
    ,
    .proto_err(proto_err_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ce_n, input logic we_n, input logic oe_n,
                               input logic ub_n, input logic lb_n, input logic [17:0] addr,
                               input logic drv, input logic [15:0] data);
    if_a.SRAM_CE_N = ce_n;
    if_a.SRAM_WE_N = we_n;
    if_a.SRAM_OE_N = oe_n;
    if_a.SRAM_UB_N = ub_n;
    if_a.SRAM_LB_N = lb_n;
    if_a.SRAM_ADDR = addr;
    tb_drv_a       = drv;
    tb_dq_a        = data;
  endtask

  task automatic applyStimulusB(input logic ce_n, input logic we_n, input logic oe_n,
                                input logic [17:0] addr, input logic drv, input logic [15:0] data);
    if_b.SRAM_CE_N = ce_n;
    if_b.SRAM_WE_N = we_n;
    if_b.SRAM_OE_N = oe_n;
    if_b.SRAM_UB_N = 1'b0;
    if_b.SRAM_LB_N = 1'b0;
    if_b.SRAM_ADDR = addr;
    tb_drv_b       = drv;
    tb_dq_b        = data;
  endtask

  // Full write on A: one commit edge, then WE_N released for one edge back to IDLE.
  task automatic writeWordA(input logic [17:0] addr, input logic [15:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr, 1'b1, data);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, addr, 1'b0, 16'h0000);
    tick();
  endtask

  // Read on A with RD_LAT=1: edge into RD_WAIT, edge into DRIVE, then sample the bus.
  task automatic readWordA(input string tag, input logic [17:0] addr, input logic [15:0] exp);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, addr, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput(tag, {16'h0, dq_a}, {16'h0, exp});
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, addr, 1'b0, 16'h0000);
    tick();
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h0, 1'b0, 16'h0);
    applyStimulusB(1'b1, 1'b1, 1'b1, 18'h0, 1'b0, 16'h0);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    checkOutput("reset_busy", {31'h0, busy_a}, 32'h0);
    checkOutput("reset_rd_count", {16'h0, rd_count_a}, 32'h0);
    checkOutput("reset_wr_count", {16'h0, wr_count_a}, 32'h0);
    checkOutput("reset_bus_released", {16'h0, dq_a}, 32'h0000_FFFF);
`ifdef SRAM_MODEL_CHECK_EN
    checkOutput("reset_proto_err", {31'h0, proto_err_a}, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // Back-to-back write burst with WE_N held low
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00010, 1'b1, 16'hBEEF);
    tick();
    checkOutput("wr1_busy", {31'h0, busy_a}, 32'h1);
    checkOutput("wr1_count", {16'h0, wr_count_a}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00011, 1'b1, 16'hDEAD);
    tick();
    checkOutput("wr2_count", {16'h0, wr_count_a}, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00011, 1'b0, 16'h0000);
    tick();
    checkOutput("wr_end_idle", {31'h0, busy_a}, 32'h0);
    checkOutput("wr_end_count", {16'h0, wr_count_a}, 32'd2);

    // Read with one RD_WAIT edge, then an address step forces a released cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00010, 1'b0, 16'h0000);
    tick();
    checkOutput("rd_wait_busy", {31'h0, busy_a}, 32'h1);
    checkOutput("rd_wait_released", {16'h0, dq_a}, 32'h0000_FFFF);
    tick();
    checkOutput("rd_0x10_data", {16'h0, dq_a}, 32'h0000_BEEF);
    checkOutput("rd_0x10_count", {16'h0, rd_count_a}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00011, 1'b0, 16'h0000);
    tick();
    checkOutput("rd_step_released", {16'h0, dq_a}, 32'h0000_FFFF);
    checkOutput("rd_step_count", {16'h0, rd_count_a}, 32'd1);
    tick();
    checkOutput("rd_0x11_data", {16'h0, dq_a}, 32'h0000_DEAD);
    checkOutput("rd_0x11_count", {16'h0, rd_count_a}, 32'd2);

    // Turnaround: WE_N falls while the model is driving 0x10
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00010, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("ta_drive_data", {16'h0, dq_a}, 32'h0000_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00010, 1'b1, 16'h5555);
    #1;
    checkOutput("ta_same_cycle_bus", {16'h0, dq_a}, 32'h0000_5555);
    tick();
    checkOutput("ta_wr_count", {16'h0, wr_count_a}, 32'd3);
    checkOutput("ta_bus_after_edge", {16'h0, dq_a}, 32'h0000_5555);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00010, 1'b0, 16'h0000);
    tick();
    readWordA("ta_readback", 18'h00010, 16'h5555);
    checkOutput("ta_rd_count", {16'h0, rd_count_a}, 32'd4);

    // Byte lanes: only the lower lane is written
    writeWordA(18'h00020, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'h00020, 1'b1, 16'hABCD);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00020, 1'b0, 16'h0000);
    tick();
    checkOutput("lane_wr_count", {16'h0, wr_count_a}, 32'd5);
    readWordA("lane_readback", 18'h00020, 16'h12CD);

    // Address wraps modulo MEM_DEPTH
    writeWordA(18'h10005, 16'h7777);
    readWordA("wrap_readback", 18'h00005, 16'h7777);
    checkOutput("wrap_rd_count", {16'h0, rd_count_a}, 32'd6);

    // Both lanes masked still counts as a committed write but changes nothing
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'h00020, 1'b1, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00020, 1'b0, 16'h0000);
    tick();
    checkOutput("mask_wr_count", {16'h0, wr_count_a}, 32'd7);
    readWordA("mask_readback", 18'h00020, 16'h12CD);

    // Deselect while in DRIVE drops straight back to IDLE
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00011, 1'b0, 16'h0000);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00011, 1'b0, 16'h0000);
    #1;
    checkOutput("desel_bus_released", {16'h0, dq_a}, 32'h0000_FFFF);
    tick();
    checkOutput("desel_idle", {31'h0, busy_a}, 32'h0);

`ifdef SRAM_MODEL_CHECK_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00030, 1'b1, 16'h0F0F);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h00030, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("proto_err_sticky", {31'h0, proto_err_a}, 32'h1);
`endif

    // Instance B, RD_LAT=3: reset in the middle of RD_WAIT
    applyStimulusB(1'b0, 1'b0, 1'b1, 18'h00011, 1'b1, 16'hDEAD);
    tick();
    applyStimulusB(1'b0, 1'b1, 1'b1, 18'h00011, 1'b0, 16'h0000);
    tick();
    checkOutput("b_wr_count", {16'h0, wr_count_b}, 32'd1);
    applyStimulusB(1'b0, 1'b1, 1'b0, 18'h00011, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("b_rd_wait_busy", {31'h0, busy_b}, 32'h1);
    rst_b = 1'b0;
    #1;
    checkOutput("b_rst_idle", {31'h0, busy_b}, 32'h0);
    checkOutput("b_rst_wr_count", {16'h0, wr_count_b}, 32'h0);
    checkOutput("b_rst_rd_count", {16'h0, rd_count_b}, 32'h0);
    checkOutput("b_rst_bus", {16'h0, dq_b}, 32'h0000_FFFF);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("b_lat3_still_wait", {16'h0, dq_b}, 32'h0000_FFFF);
    checkOutput("b_lat3_rd_count0", {16'h0, rd_count_b}, 32'h0);
    tick();
    checkOutput("b_lat3_data", {16'h0, dq_b}, 32'h0000_DEAD);
    checkOutput("b_lat3_rd_count", {16'h0, rd_count_b}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
